// File: rtl/sonuc_bcd_cevirici.sv
// sonuc_bcd_cevirici: captures the integer field of an arithmetic unit result
// on a hazir rising edge and converts it, as signed 32-bit two's complement,
// into sign plus BCD digits with a bit-serial shift-and-add-3 sequence.
module sonuc_bcd_cevirici #(
  parameter int BASAMAK = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [63:0]            sonuc,
  input  logic                   hazir,
  input  logic                   gecerli,
  input  logic                   tasma,
  output logic [4*BASAMAK-1:0]   basamaklar,
  output logic                   isaret,
  output logic                   hata,
  output logic                   mesgul,
  output logic                   cikis_gecerli
);

  localparam int BCD_W = 4 * BASAMAK;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    CEVIR = 2'd1,
    BITTI = 2'd2
  } durum_t;

  // Add 3 to every digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] basamak_duzelt(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BASAMAK; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  durum_t             durum_q, durum_d;
  logic               hazir_gecikme_q;
  logic [4:0]         sayac_q, sayac_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [31:0]        ikili_q, ikili_d;
  logic               isaret_ic_q, isaret_ic_d;
  logic               hata_ic_q, hata_ic_d;

  logic [BCD_W-1:0]   basamaklar_q;
  logic               isaret_q;
  logic               hata_q;
  logic               mesgul_q, mesgul_d;
  logic               cikis_gecerli_q;

  logic               olay_s;
  logic               yakala_s;
  logic               cevir_s;
  logic               yukle_s;
  logic [31:0]        x_s;
  logic [BCD_W-1:0]   duzeltilmis_s;

  assign olay_s        = hazir & ~hazir_gecikme_q & gecerli;
  assign x_s           = sonuc[47:16];
  assign duzeltilmis_s = basamak_duzelt(bcd_q);

  // State register; reset aborts any conversion in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q <= BOS;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Next-state logic: one capture, 32 iterations, one publish cycle.
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOS: begin
        if (olay_s) begin
          durum_d = CEVIR;
        end else begin
          durum_d = BOS;
        end
      end
      CEVIR: begin
        if (sayac_q == 5'd31) begin
          durum_d = BITTI;
        end else begin
          durum_d = CEVIR;
        end
      end
      BITTI:   durum_d = BOS;
      default: durum_d = BOS;
    endcase
  end

  // Per-state control strobes; events outside BOS are dropped.
  always_comb begin
    yakala_s = 1'b0;
    cevir_s  = 1'b0;
    yukle_s  = 1'b0;
    case (durum_q)
      BOS:     yakala_s = olay_s;
      CEVIR:   cevir_s  = 1'b1;
      BITTI:   yukle_s  = 1'b1;
      default: begin
        yakala_s = 1'b0;
        cevir_s  = 1'b0;
        yukle_s  = 1'b0;
      end
    endcase
  end

  // Working datapath: load magnitude on capture, then adjust-and-shift.
  always_comb begin
    sayac_d     = sayac_q;
    bcd_d       = bcd_q;
    ikili_d     = ikili_q;
    isaret_ic_d = isaret_ic_q;
    hata_ic_d   = hata_ic_q;
    if (yakala_s) begin
      isaret_ic_d = x_s[31];
      ikili_d     = x_s[31] ? (~x_s + 32'd1) : x_s;
      bcd_d       = '0;
      hata_ic_d   = tasma;
      sayac_d     = 5'd0;
    end else if (cevir_s) begin
      bcd_d   = {duzeltilmis_s[BCD_W-2:0], ikili_q[31]};
      ikili_d = {ikili_q[30:0], 1'b0};
      sayac_d = sayac_q + 5'd1;
    end else begin
      sayac_d = sayac_q;
    end
  end

  // Busy from the capture edge until the cycle after the publish pulse.
  always_comb begin
    mesgul_d = mesgul_q;
    if (yakala_s) begin
      mesgul_d = 1'b1;
    end else if (cikis_gecerli_q) begin
      mesgul_d = 1'b0;
    end else begin
      mesgul_d = mesgul_q;
    end
  end

  // Working registers and the hazir edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazir_gecikme_q <= 1'b1;
      sayac_q         <= 5'd0;
      bcd_q           <= '0;
      ikili_q         <= 32'd0;
      isaret_ic_q     <= 1'b0;
      hata_ic_q       <= 1'b0;
    end else begin
      hazir_gecikme_q <= hazir;
      sayac_q         <= sayac_d;
      bcd_q           <= bcd_d;
      ikili_q         <= ikili_d;
      isaret_ic_q     <= isaret_ic_d;
      hata_ic_q       <= hata_ic_d;
    end
  end

  // Output registers, updated as a whole only in the publish cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      basamaklar_q    <= '0;
      isaret_q        <= 1'b0;
      hata_q          <= 1'b0;
      mesgul_q        <= 1'b0;
      cikis_gecerli_q <= 1'b0;
    end else begin
      if (yukle_s) begin
        basamaklar_q <= bcd_q;
        // A zero result is never shown as negative.
        isaret_q     <= isaret_ic_q & (bcd_q != '0);
        hata_q       <= hata_ic_q;
      end
      mesgul_q        <= mesgul_d;
      cikis_gecerli_q <= yukle_s;
    end
  end

  assign basamaklar    = basamaklar_q;
  assign isaret        = isaret_q;
  assign hata          = hata_q;
  assign mesgul        = mesgul_q;
  assign cikis_gecerli = cikis_gecerli_q;

endmodule

// File: doc/sonuc_bcd_cevirici.md
# sonuc_bcd_cevirici

Sequential binary-to-BCD converter on the output side of the calculator's arithmetic units (toplama, cikarma, ...). It watches the unit's `hazir`/`gecerli` pair and captures the 64-bit `sonuc` word when a new result appears. It converts the integer field of that word, taken as a signed 32-bit two's-complement value, into sign plus ten BCD digits. The conversion uses shift-and-add-3 (double dabble), one bit per clock, and its outputs feed the display multiplexer.

## Interface
- `BASAMAK`, 10, number of BCD digits produced; fixed at 10, enough for 2^31 = 2147483648.
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sonuc`  in  64  result word from the arithmetic unit; the integer result is `sonuc[47:16]`, the fraction is `sonuc[15:0]`, and `sonuc[63:48]` is ignored.
- `hazir`  in  1  arithmetic unit idle/done flag.
- `gecerli`  in  1  arithmetic unit has produced at least one valid result.
- `tasma`  in  1  arithmetic overflow flag, sampled with `sonuc`.
- `basamaklar`  out  40  BCD digits; `[3:0]` is the units digit and `[39:36]` is the most significant.
- `isaret`  out  1  1 means the result is negative.
- `hata`  out  1  copy of `tasma` captured with the displayed result.
- `mesgul`  out  1  a conversion is in progress.
- `cikis_gecerli`  out  1  one-cycle pulse when `basamaklar`, `isaret` and `hata` are updated.

## Operation
- The block keeps a registered copy `hazir_d` of `hazir`.
- Capture event: `hazir & ~hazir_d & gecerli`, evaluated on a clock edge.
- FSM states: BOS (idle), CEVIR (converting), BITTI (done).
- BOS, on a capture event, goes to CEVIR:
  - `x = sonuc[47:16]`;
  - `isaret_r = x[31]`;
  - `buyukluk = x[31] ? (~x + 1) : x`, a 32-bit unsigned value (0x80000000 maps to 0x80000000);
  - the BCD shift register is cleared to 0;
  - `hata_r = tasma`;
  - `sayac = 0`.
- CEVIR, one iteration per clock:
  1. Add 3 to every 4-bit digit that is ≥5.
  2. Shift `{bcd, buyukluk}` left by one bit.
  3. Increment `sayac`.
  - After the iteration with `sayac == 31`, go to BITTI.
- BITTI:
  - load `basamaklar`, `isaret`, `hata` from the working registers;
  - assert `cikis_gecerli` for exactly one cycle;
  - return to BOS.
- Sign of zero: `isaret = 0` whenever all digits are 0.
- Capture events are ignored in CEVIR and BITTI. There is no queue; the result is dropped.
- Output registers hold their value until the next BITTI. They are never partially updated.
- `sonuc[15:0]` and `sonuc[63:48]` do not affect any output.

## Timing
- Reset values:
  - `basamaklar = 0`, `isaret = 0`, `hata = 0`, `mesgul = 0`, `cikis_gecerli = 0`;
  - state BOS, `sayac = 0`;
  - `hazir_d = 1`, so a `hazir` already high coming out of reset is not treated as an edge.
- Reset asserted mid-conversion aborts it immediately (asynchronously). Outputs return to reset values and the partial result is discarded.
- Edge numbering:
  - E0 is the capture edge;
  - E1..E32 are the 32 CEVIR iterations;
  - E33 is the BITTI update.
- After E33:
  - `cikis_gecerli` is 1 for the cycle between E33 and E34;
  - new outputs are visible from E33.
- `mesgul` is 1 from E0 through E33 and returns to 0 at E34.
- Capture-to-valid latency is 33 clocks. The earliest next capture is at E34.
- A capture event in the same cycle that BITTI returns to BOS is ignored.

## Test plan
- Value +2: `sonuc[47:16] = 0x00000002` (5-3), with a `hazir` rising edge and `gecerli = 1`. Expect `basamaklar = 40'h0000000002`, `isaret = 0`, `cikis_gecerli` pulse 33 clocks after capture.
- Value -2: `sonuc[47:16] = 0xFFFFFFFE` (3-5). Expect `basamaklar = 40'h0000000002`, `isaret = 1`.
- Extremes:
  - `0x80000000` gives `basamaklar = 40'h2147483648`, `isaret = 1`;
  - `0x7FFFFFFF` gives `40'h2147483647`, `isaret = 0`;
  - `0x00000000` gives all-zero digits, `isaret = 0`.
- No-capture cases, each with `tasma = 1`: `hazir` held high, or toggled with `gecerli = 0`. Expect no capture, `mesgul` stays 0, outputs unchanged. A later valid capture with `tasma = 1` gives `hata = 1`.
- Overlap: a second `hazir` rising edge at E10 of a conversion is ignored. Only one `cikis_gecerli` pulse occurs, and the outputs reflect the first value.
- Reset abort: `rst_n` pulled low at E15 clears all outputs without waiting for a clock edge, with no `cikis_gecerli`. After release, a fresh capture converts correctly.
